hazard_forward_unit: RTL and testbench

Parametrised hazard and forwarding unit for the 5-stage RISC-V pipeline. It generates per-source-operand forwarding selects from the EX/MEM and MEM/WB stages and detects load-use hazards. It also adds a scoreboard for one multi-cycle execution unit (divider/multiplier) and a saturating stall-cycle counter. It sits between the pipeline registers and the EX operand muxes, and drives the stall/bubble controls of the IF/ID and ID/EX registers.

---
 rtl/hazard_forward_unit.sv | 128 ++++++++++++
 tb/tb_hazard_forward_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit for the 5-stage RISC-V pipeline, with a multi-cycle unit scoreboard.
// Latency: fwd_sel/stall are combinational; the scoreboard and stall counter update on the rising clk edge.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; there is no flow control towards this block.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_valid/id_rs/id_rs_used/id_mc       instruction in ID (sources, which are read, multi-cycle flag)
//   ex_valid/ex_reg_write/ex_mem_read/ex_mc_start/ex_rd/ex_rs   instruction in EX
//   mem_reg_write/mem_rd, wb_reg_write/wb_rd                    later-stage write-back info
//   fwd_sel                        per operand 2 bits: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall                          load-use, multi-cycle RAW or multi-cycle structural hazard
//   mc_busy/mc_done/mc_rd          multi-cycle unit occupancy, last busy cycle, destination
//   mc_overlap_err                 sticky: start seen while the unit was busy
//   stall_count                    saturating count of stall cycles
module hazard_forward_unit #(
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int NUM_RS          = 2,
   parameter int MC_LATENCY      = 4,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             id_valid,
   input  logic [NUM_RS*REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [NUM_RS-1:0]                id_rs_used,
   input  logic                             id_mc,
   input  logic                             ex_valid,
   input  logic                             ex_reg_write,
   input  logic                             ex_mem_read,
   input  logic                             ex_mc_start,
   input  logic [REG_ADDR_WIDTH-1:0]        ex_rd,
   input  logic [NUM_RS*REG_ADDR_WIDTH-1:0] ex_rs,
   input  logic                             mem_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0]        mem_rd,
   input  logic                             wb_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0]        wb_rd,
   output logic [2*NUM_RS-1:0]              fwd_sel,
   output logic                             stall,
   output logic                             mc_busy,
   output logic                             mc_done,
   output logic [REG_ADDR_WIDTH-1:0]        mc_rd,
   output logic                             mc_overlap_err,
   output logic [STALL_CNT_WIDTH-1:0]       stall_count
);

   localparam int W     = REG_ADDR_WIDTH;
   localparam int CNT_W = $clog2(MC_LATENCY + 1);
   localparam logic [CNT_W-1:0]           MC_LOAD   = CNT_W'(MC_LATENCY);
   localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

   logic [CNT_W-1:0]           mc_cnt_q, mc_cnt_d;
   logic [W-1:0]               mc_rd_q, mc_rd_d;
   logic                       mc_err_q, mc_err_d;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use_match, mc_raw_match;
   logic load_use, mc_raw, mc_struct, mc_start;

   // A load always writes its rd, so the load-use check keys on ex_mem_read alone.
   logic unused_ex_reg_write;
   assign unused_ex_reg_write = ex_reg_write;

   // EX/MEM has priority over MEM/WB because it carries the younger value.
   always_comb begin
      fwd_sel = '0;
      if (!rst) begin
         for (int i = 0; i < NUM_RS; i++) begin
            if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs[i*W +: W])
               fwd_sel[2*i +: 2] = 2'b10;
            else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs[i*W +: W])
               fwd_sel[2*i +: 2] = 2'b01;
         end
      end
   end

   always_comb begin
      load_use_match = 1'b0;
      mc_raw_match   = 1'b0;
      for (int i = 0; i < NUM_RS; i++) begin
         if (id_rs_used[i] && id_rs[i*W +: W] == ex_rd)   load_use_match = 1'b1;
         if (id_rs_used[i] && id_rs[i*W +: W] == mc_rd_q) mc_raw_match   = 1'b1;
      end
   end

   assign mc_busy   = (mc_cnt_q != '0);
   assign mc_done   = (mc_cnt_q == CNT_W'(1));
   assign mc_start  = ex_valid && ex_mc_start;
   assign load_use  = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && load_use_match;
   assign mc_raw    = mc_busy && (mc_rd_q != '0) && id_valid && mc_raw_match;
   assign mc_struct = mc_busy && id_valid && id_mc;
   assign stall     = !rst && (load_use || mc_raw || mc_struct);

   // A start on the final busy edge still sees mc_busy=1, so it is dropped and flagged.
   always_comb begin
      mc_cnt_d    = mc_cnt_q;
      mc_rd_d     = mc_rd_q;
      mc_err_d    = mc_err_q;
      stall_cnt_d = stall_cnt_q;
      if (mc_busy) begin
         mc_cnt_d = mc_cnt_q - CNT_W'(1);
         if (mc_start) mc_err_d = 1'b1;
      end else if (mc_start) begin
         mc_cnt_d = MC_LOAD;
         mc_rd_d  = ex_rd;
      end
      if (stall && stall_cnt_q != STALL_MAX)
         stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mc_cnt_q    <= '0;
         mc_rd_q     <= '0;
         mc_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         mc_cnt_q    <= mc_cnt_d;
         mc_rd_q     <= mc_rd_d;
         mc_err_q    <= mc_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mc_rd          = mc_rd_q;
   assign mc_overlap_err = mc_err_q;
   assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

   localparam int W  = 5;
   localparam int NR = 2;
   localparam int CW = 4;

   localparam int SIG_FWD   = 0;
   localparam int SIG_STALL = 1;
   localparam int SIG_BUSY  = 2;
   localparam int SIG_DONE  = 3;
   localparam int SIG_RD    = 4;
   localparam int SIG_ERR   = 5;
   localparam int SIG_CNT   = 6;

   logic            clk, rst;
   logic            id_valid, id_mc;
   logic [NR*W-1:0] id_rs, ex_rs;
   logic [NR-1:0]   id_rs_used;
   logic            ex_valid, ex_reg_write, ex_mem_read, ex_mc_start;
   logic [W-1:0]    ex_rd, mem_rd, wb_rd;
   logic            mem_reg_write, wb_reg_write;
   logic [2*NR-1:0] fwd_sel;
   logic            stall, mc_busy, mc_done, mc_overlap_err;
   logic [W-1:0]    mc_rd;
   logic [CW-1:0]   stall_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   string       tag_q[$];
   int          sig_q[$];
   logic [31:0] exp_q[$];

   hazard_forward_unit #(
      .REG_ADDR_WIDTH(W), .NUM_RS(NR), .MC_LATENCY(4), .STALL_CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used), .id_mc(id_mc),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mc_start(ex_mc_start), .ex_rd(ex_rd), .ex_rs(ex_rs),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .fwd_sel(fwd_sel), .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done),
      .mc_rd(mc_rd), .mc_overlap_err(mc_overlap_err), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] obs(input int sig);
      case (sig)
         SIG_FWD:   obs = 32'(fwd_sel);
         SIG_STALL: obs = 32'(stall);
         SIG_BUSY:  obs = 32'(mc_busy);
         SIG_DONE:  obs = 32'(mc_done);
         SIG_RD:    obs = 32'(mc_rd);
         SIG_ERR:   obs = 32'(mc_overlap_err);
         SIG_CNT:   obs = 32'(stall_count);
         default:   obs = 'x;
      endcase
   endfunction

   task automatic push(input string tag, input int sig, input logic [31:0] val);
      tag_q.push_back(tag);
      sig_q.push_back(sig);
      exp_q.push_back(val);
   endtask

   task automatic push_mc(input string tag, input logic busy, input logic done,
                          input logic [W-1:0] rd, input logic stl);
      push({tag, ".busy"},  SIG_BUSY,  32'(busy));
      push({tag, ".done"},  SIG_DONE,  32'(done));
      push({tag, ".rd"},    SIG_RD,    32'(rd));
      push({tag, ".stall"}, SIG_STALL, 32'(stl));
      push({tag, ".cnt"},   SIG_CNT,   32'(exp_cnt));
   endtask

   // Drains the scoreboard against the DUT outputs as they stand now.
   task automatic check_all();
      string       t;
      int          s;
      logic [31:0] e, o;
      while (tag_q.size() > 0) begin
         t = tag_q.pop_front();
         s = sig_q.pop_front();
         e = exp_q.pop_front();
         o = obs(s);
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", t, o, e);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle_check();
      #1;
      check_all();
   endtask

   task automatic stall_edge();
      step();
      if (exp_cnt < 15) exp_cnt++;
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_mc = 0; id_rs = '0; id_rs_used = '0;
      ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mc_start = 0;
      ex_rd = '0; ex_rs = '0;
      mem_reg_write = 0; mem_rd = '0; wb_reg_write = 0; wb_rd = '0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      // Forwarding match present while in reset: fwd_sel must still be forced to 0.
      mem_reg_write = 1; mem_rd = 5; ex_rs = {5'd0, 5'd5};
      #2;
      push("rst.fwd", SIG_FWD, 0);
      push("rst.err", SIG_ERR, 0);
      push_mc("rst", 0, 0, 0, 0);
      check_all();
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();

      // Forwarding priority and zero-register guard
      step();
      ex_rs = {5'd0, 5'd5};
      mem_reg_write = 1; mem_rd = 5; wb_reg_write = 1; wb_rd = 5;
      push("fwd.mem_prio", SIG_FWD, 4'b0010);
      settle_check();
      mem_reg_write = 0;
      push("fwd.wb", SIG_FWD, 4'b0001);
      settle_check();
      mem_reg_write = 1; ex_rs = {5'd5, 5'd3}; wb_rd = 3;
      push("fwd.per_operand", SIG_FWD, 4'b1001);
      settle_check();
      mem_rd = 0; wb_rd = 0; ex_rs = {5'd5, 5'd5};
      push("fwd.rd_zero", SIG_FWD, 4'b0000);
      settle_check();
      ex_rs = '0;
      push("fwd.x0", SIG_FWD, 4'b0000);
      settle_check();
      clear_inputs();

      // Load-use: one stall cycle, then forwarding from MEM/WB
      step();
      ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7;
      id_valid = 1; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
      push("lu.stall", SIG_STALL, 1);
      push("lu.cnt0", SIG_CNT, 0);
      settle_check();
      stall_edge();
      ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
      mem_reg_write = 1; mem_rd = 7;
      push("lu.bubble_stall", SIG_STALL, 0);
      push("lu.cnt1", SIG_CNT, 32'(exp_cnt));
      settle_check();
      step();
      mem_reg_write = 0; mem_rd = 0; wb_reg_write = 1; wb_rd = 7;
      ex_rs = {5'd7, 5'd0}; id_valid = 0;
      push("lu.fwd_wb", SIG_FWD, 4'b0100);
      push("lu.cnt_hold", SIG_CNT, 32'(exp_cnt));
      settle_check();
      clear_inputs();

      step();
      ex_valid = 1; ex_mem_read = 1; ex_rd = 7;
      id_valid = 1; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b00;
      push("lu.unused", SIG_STALL, 0);
      settle_check();
      id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
      push("lu.op0", SIG_STALL, 1);
      settle_check();
      ex_rd = 0; id_rs = '0; id_rs_used = 2'b11;
      push("lu.x0", SIG_STALL, 0);
      settle_check();
      id_valid = 0; ex_rd = 7; id_rs = {5'd7, 5'd7};
      push("lu.id_invalid", SIG_STALL, 0);
      settle_check();
      clear_inputs();

      // Multi-cycle RAW
      step();
      ex_valid = 1; ex_mc_start = 1; ex_rd = 9;
      id_valid = 1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      push("mc.pre_stall", SIG_STALL, 0);
      push("mc.pre_busy", SIG_BUSY, 0);
      settle_check();
      step();
      ex_valid = 0; ex_mc_start = 0; ex_rd = 0;
      for (int k = 1; k <= 4; k++) begin
         push_mc($sformatf("mc.raw_c%0d", k), 1, (k == 4), 9, 1);
         settle_check();
         stall_edge();
      end
      push_mc("mc.raw_after", 0, 0, 9, 0);
      settle_check();
      clear_inputs();

      // Structural hazard and overlap error
      step();
      ex_valid = 1; ex_mc_start = 1; ex_rd = 9;
      settle_check();
      step();
      ex_valid = 0; ex_mc_start = 0; ex_rd = 0;
      id_valid = 1; id_mc = 1;
      push_mc("st.c1", 1, 0, 9, 1);
      push("st.c1.err", SIG_ERR, 0);
      settle_check();
      stall_edge();
      ex_valid = 1; ex_mc_start = 1; ex_rd = 12;
      push_mc("st.c2", 1, 0, 9, 1);
      push("st.c2.err", SIG_ERR, 0);
      settle_check();
      stall_edge();
      ex_valid = 0; ex_mc_start = 0; ex_rd = 0;
      push_mc("st.c3", 1, 0, 9, 1);
      push("st.c3.err", SIG_ERR, 1);
      settle_check();
      stall_edge();
      push_mc("st.c4", 1, 1, 9, 1);
      settle_check();
      stall_edge();
      push_mc("st.c5", 0, 0, 9, 0);
      push("st.c5.err", SIG_ERR, 1);
      settle_check();
      step();
      push("st.err_sticky", SIG_ERR, 1);
      settle_check();
      clear_inputs();

      // Asynchronous reset in the middle of an operation
      step();
      ex_valid = 1; ex_mc_start = 1; ex_rd = 9;
      id_valid = 1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      settle_check();
      step();
      ex_valid = 0; ex_mc_start = 0; ex_rd = 0;
      stall_edge();
      push_mc("ar.c2", 1, 0, 9, 1);
      settle_check();
      #1 rst = 1'b1;
      #1;
      exp_cnt = 0;
      push_mc("ar.in_rst", 0, 0, 0, 0);
      push("ar.err", SIG_ERR, 0);
      check_all();
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();

      // Stall counter saturation
      step();
      ex_valid = 1; ex_mem_read = 1; ex_rd = 7;
      id_valid = 1; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
      push("sat.stall", SIG_STALL, 1);
      settle_check();
      for (int k = 0; k < 20; k++) begin
         stall_edge();
         push($sformatf("sat.cnt%0d", k), SIG_CNT, 32'(exp_cnt));
         settle_check();
      end
      clear_inputs();
      step();
      push("sat.final", SIG_CNT, 15);
      push("sat.stall_off", SIG_STALL, 0);
      settle_check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
